ah_demux_pkt_reg: RTL and testbench
===================================

// Module: ah_demux_pkt_reg
// PURPOSE
//  Registered, packet-aware 1:N demultiplexer with valid/ready handshake.
//  Routes each ingress beat to one of NUM_EGR egress ports through a one-entry output stage.
//  The destination is sampled on the first beat of a packet and locked until the beat with ing_last is accepted.
//  Sits between a packet source and per-destination consumers in the AH datapath; supersedes the combinational fixed-width demux.
// PARAMETERS
//  DATA_W   85  payload width per beat
//  NUM_EGR  16  number of egress ports, 2..256
//  SEL_W    4   width of ing_select; must satisfy 2**SEL_W >= NUM_EGR
//  CNT_W    16  drop counter width (used only with AH_DEMUX_DROP_EN)
// PORTS
//  clk         in   1               clock; all logic on the rising edge
//  rst         in   1               synchronous, active-high reset
//  ing_select  in   SEL_W           destination index; sampled on the first beat of a packet only
//  ing_data    in   DATA_W          ingress payload
//  ing_last    in   1               final beat of the packet
//  ing_valid   in   1               ingress beat valid
//  ing_ready   out  1               ingress beat accepted when ing_valid&&ing_ready
//  egr_data    out  NUM_EGR*DATA_W  lane k = bits [k*DATA_W +: DATA_W]
//  egr_last    out  NUM_EGR         per-lane last
//  egr_valid   out  NUM_EGR         per-lane valid; at most one bit set
//  egr_ready   in   NUM_EGR         per-lane ready
//  drop_cnt    out  CNT_W           present only with AH_DEMUX_DROP_EN
// BEHAVIOUR
//  - Reset: ing_ready=0 during rst; egr_valid=0, egr_last=0, egr_data=0; FSM=IDLE; drop_cnt=0.
//  - Output stage: registers o_valid, o_dest, o_data, o_last.
//    - egr_valid[k] = o_valid && (o_dest==k).
//    - egr_data and egr_last for lane k equal o_data/o_last when o_dest==k, else 0.
//  - Stage can load when !o_valid || egr_ready[o_dest].
//    - ing_ready = can_load && route_ok, combinational.
//    - Full throughput: 1 beat/cycle while the selected lane holds ready.
//  - Latency: beat accepted in cycle n appears on egress in cycle n+1.
//  - egress handshake: a beat is held stable until egr_ready[o_dest]=1. A lane's ready has no effect when that lane's valid=0.
//  - FSM:
//    - IDLE: dest = ing_select.
//      - On accept with ing_last=0: lock dest into cur_dest and go to PKT.
//      - On accept with ing_last=1: single-beat packet; stay in IDLE.
//    - PKT: dest = cur_dest; ing_select is ignored.
//      - On accept with ing_last=1: go to IDLE.
//  - route_ok = (dest < NUM_EGR).
//  - Back-to-back packets to different lanes: the first beat of the new packet may load in the same cycle the last beat of the old one drains. No bubble.
//  - ing_valid=0 in PKT: remain in PKT; the output stage drains normally.
//  - rst mid-packet: the in-flight beat and the locked destination are discarded. The next accepted beat is treated as a first beat.
// CONFIGURATION
//  - AH_DEMUX_DROP_EN defined:
//    - A packet whose first-beat ing_select >= NUM_EGR is dropped. All of its beats are accepted (ing_ready = 1) and never reach the output stage.
//    - While dropping, the FSM uses state DROP in place of PKT; a single-beat packet is dropped from IDLE.
//    - drop_cnt counts dropped packets, +1 when the last beat is accepted, and saturates at all-ones.
//  - AH_DEMUX_DROP_EN undefined:
//    - An out-of-range select holds ing_ready = 0 (stall) until the select changes. No DROP state and no drop_cnt port.
// TESTING
//  1. Hold rst=1 for 3 cycles with ing_valid=1 -> ing_ready=0 and egr_valid=0 throughout. The first cycle after reset shows egr_valid=0.
//  2. Single beat: select=5, data=85'h1ABC, last=1, egr_ready all 1 -> in the next cycle egr_valid=16'h0020 and lane5 data=85'h1ABC with egr_last[5]=1. All other lanes read 0.
//  3. 4-beat packet: first beat select=3, later beats select=9. egr_ready[3] toggles 1,0,1,1,0,1 -> all 4 beats appear on lane 3 in order and none is duplicated. ing_ready follows egr_ready[3].
//  4. Back-to-back traffic with egr_ready all 1:
//     - 2-beat packet to lane 0, then 1-beat packet to lane 15, on consecutive cycles
//     - egr_valid sequence is 0x0001, 0x0001, 0x8000 with no idle cycle between them
//  5. With DROP_EN and NUM_EGR=12: a 3-beat packet with select=13 is accepted in 3 cycles, egr_valid stays 0 and drop_cnt reads 1. Without DROP_EN, the same stimulus gives ing_ready=0 indefinitely.
//  6. Assert rst during beat 2 of a 4-beat packet to lane 7, then send a 1-beat packet with select=2 -> output on lane 2 and nothing further on lane 7.

Source files
------------

// File: rtl/ah_demux_pkt_reg.sv
// ah_demux_pkt_reg: registered, packet-aware 1:N demultiplexer with valid/ready handshake.
// Each ingress beat is routed to one of NUM_EGR egress lanes through a one-entry output stage.
// The destination is taken from ing_select on a packet's first beat and held until its last beat.
// Optional feature macro: AH_DEMUX_DROP_EN drops packets whose first-beat select is out of range
// and counts them on drop_cnt; without it, an out-of-range select stalls the ingress.
module ah_demux_pkt_reg #(
    parameter int unsigned DATA_W  = 85,
    parameter int unsigned NUM_EGR = 16,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEL_W-1:0]            ing_select,
    input  logic [DATA_W-1:0]           ing_data,
    input  logic                        ing_last,
    input  logic                        ing_valid,
    output logic                        ing_ready,
    output logic [NUM_EGR*DATA_W-1:0]   egr_data,
    output logic [NUM_EGR-1:0]          egr_last,
    output logic [NUM_EGR-1:0]          egr_valid,
    input  logic [NUM_EGR-1:0]          egr_ready
`ifdef AH_DEMUX_DROP_EN
    ,
    output logic [CNT_W-1:0]            drop_cnt
`endif
);

    // Elaboration-time parameter sanity checks.
    if ((2 ** SEL_W) < NUM_EGR) begin : g_sel_w_check
        $error("SEL_W too narrow for NUM_EGR");
    end
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_dest_q, cur_dest_d;

    logic               o_valid_q;
    logic [SEL_W-1:0]   o_dest_q;
    logic [DATA_W-1:0]  o_data_q;
    logic               o_last_q;

    logic [SEL_W-1:0]   dest;
    logic               route_ok;
    logic               lane_ready;
    logic               can_load;
    logic               drop_beat;
    logic               accept;
    logic               load;

    // Fan the output stage out to its lane and pick up that lane's ready.
    always_comb begin
        lane_ready = 1'b0;
        egr_valid  = '0;
        egr_last   = '0;
        egr_data   = '0;
        for (int k = 0; k < NUM_EGR; k++) begin
            if (o_dest_q == SEL_W'(k)) begin
                lane_ready                   = egr_ready[k];
                egr_valid[k]                 = o_valid_q;
                egr_last[k]                  = o_last_q;
                egr_data[k*DATA_W +: DATA_W] = o_data_q;
            end
        end
    end

    assign dest     = (state_q == StIdle) ? ing_select : cur_dest_q;
    assign route_ok = 32'(dest) < NUM_EGR;
    // A draining beat frees the stage in the same cycle, so packets flow back-to-back.
    assign can_load = !o_valid_q || lane_ready;

`ifdef AH_DEMUX_DROP_EN
    assign drop_beat = (state_q == StDrop) || ((state_q == StIdle) && !route_ok);
`else
    assign drop_beat = 1'b0;
`endif

    assign ing_ready = !rst && (drop_beat || (can_load && route_ok));
    assign accept    = ing_valid && ing_ready;
    assign load      = accept && !drop_beat;

    // Packet FSM: lock the destination on the first beat, release on the last.
    always_comb begin
        state_d    = state_q;
        cur_dest_d = cur_dest_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !ing_last) begin
                    state_d    = drop_beat ? StDrop : StPkt;
                    cur_dest_d = ing_select;
                end
            end
            StPkt, StDrop: begin
                if (accept && ing_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and locked destination registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_dest_q <= cur_dest_d;
        end
    end

    // One-entry output stage: load on accept, clear valid when the lane takes the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_dest_q  <= '0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
        end else if (load) begin
            o_valid_q <= 1'b1;
            o_dest_q  <= dest;
            o_data_q  <= ing_data;
            o_last_q  <= ing_last;
        end else if (o_valid_q && lane_ready) begin
            o_valid_q <= 1'b0;
        end
    end

`ifdef AH_DEMUX_DROP_EN
    logic [CNT_W-1:0] drop_cnt_q;

    // Count dropped packets on their last beat, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (accept && drop_beat && ing_last && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ah_demux_pkt_reg.sv
// Testbench for ah_demux_pkt_reg: directed and randomized traffic against a packet-level model.
// Works with or without AH_DEMUX_DROP_EN defined.
module tb_ah_demux_pkt_reg;

    localparam int unsigned DW = 85;
    localparam int unsigned NE = 12;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 3;
    localparam int          CNT_MAX = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic [SW-1:0]       ing_select;
    logic [DW-1:0]       ing_data;
    logic                ing_last;
    logic                ing_valid;
    logic                ing_ready;
    logic [NE*DW-1:0]    egr_data;
    logic [NE-1:0]       egr_last;
    logic [NE-1:0]       egr_valid;
    logic [NE-1:0]       egr_ready;
`ifdef AH_DEMUX_DROP_EN
    logic [CW-1:0]       drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: slot contents, packet lock (-1 = between packets), drop flag, drop count.
    bit          m_valid   = 1'b0;
    int          m_dest    = 0;
    logic [DW-1:0] m_data  = '0;
    bit          m_last    = 1'b0;
    int          locked    = -1;
    bit          dropping  = 1'b0;
    int          m_cnt     = 0;

    ah_demux_pkt_reg #(
        .DATA_W  (DW),
        .NUM_EGR (NE),
        .SEL_W   (SW),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ing_select (ing_select),
        .ing_data   (ing_data),
        .ing_last   (ing_last),
        .ing_valid  (ing_valid),
        .ing_ready  (ing_ready),
        .egr_data   (egr_data),
        .egr_last   (egr_last),
        .egr_valid  (egr_valid),
        .egr_ready  (egr_ready)
`ifdef AH_DEMUX_DROP_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check ing_ready, advance model.
    task automatic step(input bit r, input bit v, input int sel, input logic [DW-1:0] d,
                        input bit l, input logic [NE-1:0] rdy);
        logic [NE-1:0] exp_valid;
        logic [NE-1:0] exp_last;
        int  dest;
        bit  ok, free, drop_now, exp_rdy, acc;

        @(negedge clk);
        exp_valid = '0;
        exp_last  = '0;
        if (m_valid) exp_valid[m_dest] = 1'b1;
        exp_last[m_dest] = m_last;
        check("egr_valid", 128'(egr_valid), 128'(exp_valid));
        check("egr_last", 128'(egr_last), 128'(exp_last));
        for (int k = 0; k < NE; k++) begin
            check($sformatf("egr_data[%0d]", k), 128'(egr_data[k*DW +: DW]),
                  (k == m_dest) ? 128'(m_data) : 128'(0));
        end
`ifdef AH_DEMUX_DROP_EN
        check("drop_cnt", 128'(drop_cnt), 128'(m_cnt));
`endif

        rst        = r;
        ing_valid  = v;
        ing_select = SW'(sel);
        ing_data   = d;
        ing_last   = l;
        egr_ready  = rdy;
        #1;

        dest = (locked >= 0) ? locked : sel;
        ok   = dest < int'(NE);
        free = !m_valid || rdy[m_dest];
`ifdef AH_DEMUX_DROP_EN
        drop_now = dropping || (locked < 0 && !ok);
`else
        drop_now = 1'b0;
`endif
        exp_rdy = !r && (drop_now || (free && ok));
        check("ing_ready", 128'(ing_ready), 128'(exp_rdy));

        if (r) begin
            m_valid = 0; m_dest = 0; m_data = '0; m_last = 0;
            locked = -1; dropping = 0; m_cnt = 0;
        end else begin
            acc = v && exp_rdy;
            if (m_valid && rdy[m_dest]) m_valid = 0;
            if (acc) begin
                if (drop_now) begin
                    dropping = !l;
                    if (l && m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    m_valid = 1;
                    m_dest  = dest;
                    m_data  = d;
                    m_last  = l;
                    locked  = l ? -1 : dest;
                end
            end
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    initial begin
        logic [NE-1:0] rdy;
        int sel;
        rst = 1'b1; ing_valid = 1'b0; ing_select = '0; ing_data = '0; ing_last = 1'b0;
        egr_ready = '1;

        // Reset held with valid asserted, then one idle cycle.
        repeat (3) step(1, 1, 5, rand_data(), 0, '1);
        step(0, 0, 0, '0, 0, '1);

        // Single beat to lane 5.
        step(0, 1, 5, 85'h1ABC, 1, '1);
        step(0, 0, 0, '0, 0, '1);

        // 4-beat packet locked to lane 3 while select changes; lane 3 ready toggles.
        step(0, 1, 3, rand_data(), 0, '1);
        step(0, 1, 9, rand_data(), 0, '0);
        step(0, 1, 9, rand_data(), 0, '1);
        step(0, 1, 9, rand_data(), 1, '1);
        step(0, 0, 9, '0, 0, '0);
        step(0, 0, 9, '0, 0, '1);

        // Back-to-back: 2 beats to lane 0, then 1 beat to lane 11.
        step(0, 1, 0, rand_data(), 0, '1);
        step(0, 1, 0, rand_data(), 1, '1);
        step(0, 1, 11, rand_data(), 1, '1);
        step(0, 0, 0, '0, 0, '1);

        // Out-of-range 3-beat packet: dropped or stalled depending on build.
        step(0, 1, 13, rand_data(), 0, '1);
        step(0, 1, 13, rand_data(), 0, '1);
        step(0, 1, 13, rand_data(), 1, '1);
        step(0, 0, 0, '0, 0, '1);

        // Reset in the middle of a packet to lane 7, then a single beat to lane 2.
        step(0, 1, 7, rand_data(), 0, '1);
        step(1, 1, 7, rand_data(), 0, '1);
        step(0, 1, 2, rand_data(), 1, '1);
        step(0, 0, 0, '0, 0, '1);
        step(0, 0, 0, '0, 0, '1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < NE; k++) rdy[k] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) sel = $urandom_range(NE, 15);
            else sel = $urandom_range(0, NE - 1);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), sel, rand_data(),
                 ($urandom_range(0, 2) == 0), rdy);
        end
        step(0, 0, 0, '0, 0, '1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
